// File: rtl/rv32_multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback sequencing,
// one-hot instruction classing, memory wait timeout and retired-instruction counting.
module rv32_multicycle_ctrl #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_load,
  output logic [9:0]  code,
  output logic        alu_sel_B,
  output logic        reg_we,
  output logic        pc_we,
  output logic [31:0] instret,
  output logic        illegal,
  output logic        timeout
);

  typedef enum logic [2:0] {
    BOOT,
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    TRAP
  } state_t;

  state_t      state_q, state_d;
  logic [9:0]  code_q;
  logic [9:0]  dec_code;
  logic [7:0]  wait_q;
  logic [31:0] instret_q;
  logic        illegal_q;
  logic        timeout_q;
  logic        timeout_set;
  logic        wait_expired;

  always_comb begin
    dec_code = '0;
    case (opcode)
      7'b1101111: dec_code = 10'h001;
      7'b1100111: dec_code = 10'h002;
      7'b0110111: dec_code = 10'h004;
      7'b0010111: dec_code = 10'h008;
      7'b1100011: dec_code = 10'h010;
      7'b0110011: dec_code = 10'h020;
      7'b0100011: dec_code = 10'h040;
      7'b0010011: dec_code = 10'h080;
      7'b0000011: dec_code = 10'h100;
      7'b1110011: dec_code = 10'h200;
      default:    dec_code = '0;
    endcase
  end

  // The cycle that would bring the wait count up to TIMEOUT traps, unless acked.
  assign wait_expired = (({1'b0, wait_q} + 9'd1) == 9'(TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    ir_load     = 1'b0;
    reg_we      = 1'b0;
    pc_we       = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      BOOT: state_d = FETCH;
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_load = 1'b1;
          state_d = DECODE;
        end else if (wait_expired) begin
          timeout_set = 1'b1;
          state_d     = TRAP;
        end
      end
      DECODE: state_d = (dec_code == '0) ? TRAP : EXEC;
      EXEC: begin
        if (code_q[4]) begin
          pc_we   = 1'b1;
          state_d = FETCH;
        end else if (code_q[6] || code_q[8]) begin
          state_d = MEM;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = code_q[6];
        if (mem_ack) begin
          pc_we   = code_q[6];
          state_d = code_q[6] ? FETCH : WB;
        end else if (wait_expired) begin
          timeout_set = 1'b1;
          state_d     = TRAP;
        end
      end
      WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code_q    <= '0;
      wait_q    <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == DECODE) begin
        code_q <= dec_code;
        if (dec_code == '0) illegal_q <= 1'b1;
      end
      if (timeout_set) timeout_q <= 1'b1;
      instret_q <= instret_q + {31'd0, pc_we};
      // Count restarts on every fresh entry into a memory-wait state.
      if ((state_d != state_q) && ((state_d == FETCH) || (state_d == MEM))) begin
        wait_q <= '0;
      end else if (mem_req && !mem_ack) begin
        wait_q <= wait_q + 8'd1;
      end
    end
  end

  assign code      = code_q;
  assign alu_sel_B = ~(code_q[4] | code_q[5]);
  assign instret   = instret_q;
  assign illegal   = illegal_q;
  assign timeout   = timeout_q;

endmodule
